// File: rtl/edsac_teleprinter.sv
// EDSAC teleprinter output path: 5-bit teleprinter codes are translated to ASCII
// and queued in a show-ahead FIFO, with figures/letters shift and automatic line wrap.
module edsac_teleprinter #(
   parameter int FIFO_DEPTH = 16,
   parameter int LINE_WIDTH = 72
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          char_strobe,
   input  logic [4:0]                    char_code,
   output logic [7:0]                    ascii_data,
   output logic                          ascii_valid,
   input  logic                          ascii_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          figures,
   output logic                          busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int COL_W = $clog2(LINE_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, EMIT_CR, EMIT_LF, EMIT_CHAR} state_t;

   state_t             state, state_next;
   logic               strobe_q;
   logic               char_event_p0;
   logic               wrap_p0;
   logic [4:0]         char_code_p1;
   logic [7:0]         char_byte_p1;
   logic [COL_W-1:0]   column;
   logic               push_req;
   logic [7:0]         push_byte;
   logic               push_ok;
   logic               pop;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [7:0]         mem [FIFO_DEPTH];

   function automatic logic is_printing(input logic [4:0] code);
      return !(code == 5'd11 || code == 5'd15 || code == 5'd16 ||
               code == 5'd18 || code == 5'd24);
   endfunction

   function automatic logic emits_byte(input logic [4:0] code);
      return !(code == 5'd11 || code == 5'd15 || code == 5'd16);
   endfunction

   function automatic logic [7:0] edsac_to_ascii(input logic [4:0] code, input logic fig);
      logic [7:0] b;
      if (fig && code < 5'd10) return 8'h30 + {3'b000, code};
      case (code)
         5'd0:  b = "P";   5'd1:  b = "Q";   5'd2:  b = "W";   5'd3:  b = "E";
         5'd4:  b = "R";   5'd5:  b = "T";   5'd6:  b = "Y";   5'd7:  b = "U";
         5'd8:  b = "I";   5'd9:  b = "O";   5'd10: b = "J";   5'd12: b = "S";
         5'd13: b = "Z";   5'd14: b = "K";   5'd17: b = "F";   5'd18: b = 8'h0D;
         5'd19: b = "D";   5'd20: b = 8'h20; 5'd21: b = "H";   5'd22: b = "N";
         5'd23: b = "M";   5'd24: b = 8'h0A; 5'd25: b = "L";   5'd26: b = "X";
         5'd27: b = "G";   5'd28: b = "A";   5'd29: b = "B";   5'd30: b = "C";
         5'd31: b = "V";
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign char_event_p0 = char_strobe & ~strobe_q;
   assign wrap_p0       = is_printing(char_code) && (column == COL_W'(LINE_WIDTH));

   // Emit FSM: state register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (char_event_p0 && emits_byte(char_code))
                       state_next = wrap_p0 ? EMIT_CR : EMIT_CHAR;
         EMIT_CR:   state_next = EMIT_LF;
         EMIT_LF:   state_next = EMIT_CHAR;
         EMIT_CHAR: state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      push_req  = (state != IDLE);
      push_byte = 8'h00;
      case (state)
         EMIT_CR:   push_byte = 8'h0D;
         EMIT_LF:   push_byte = 8'h0A;
         EMIT_CHAR: push_byte = char_byte_p1;
         default:   push_byte = 8'h00;
      endcase
   end

   // Character capture: translation uses the shift state in force at the event
   always_ff @(posedge clock) begin
      if (char_event_p0 && state == IDLE) begin
         char_code_p1 <= char_code;
         char_byte_p1 <= edsac_to_ascii(char_code, figures);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         strobe_q <= char_strobe;
         figures  <= 1'b0;
         column   <= '0;
         overflow <= 1'b0;
      end else begin
         strobe_q <= char_strobe;
         if (char_event_p0 && state == IDLE) begin
            if (char_code == 5'd11) figures <= 1'b1;
            if (char_code == 5'd15) figures <= 1'b0;
         end
         if ((char_event_p0 && busy) || (push_req && !push_ok)) overflow <= 1'b1;
         if (state == EMIT_CR) column <= '0;
         if (state == EMIT_CHAR) begin
            if (char_code_p1 == 5'd18)          column <= '0;
            else if (is_printing(char_code_p1)) column <= column + 1'b1;
         end
      end
   end

   // Output FIFO: a full FIFO still accepts a push when a pop frees a slot this cycle
   assign ascii_valid = (fifo_count != '0);
   assign ascii_data  = ascii_valid ? mem[rd_ptr] : 8'h00;
   assign pop         = ascii_valid & ascii_ready;
   assign push_ok     = push_req && ((fifo_count < (PTR_W+1)'(FIFO_DEPTH)) || pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_byte;
   end

endmodule
